// File: rtl/keccak_absorb_stream.sv
// Keccak absorb front-end: XORs a byte-keyed stream into the 1600-bit state,
// hands full rate blocks to the permutation core and applies suffix + pad10*1.
module keccak_absorb_stream #(
   parameter int DWIDTH     = 256,
   parameter int KEEP_WIDTH = DWIDTH/8,
   parameter int MAX_RATE   = 1344,
   parameter int RATE_WIDTH = 11
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [RATE_WIDTH-1:0] rate_i,
   input  logic [7:0]            dsbyte_i,
   input  logic [DWIDTH-1:0]     s_data_i,
   input  logic [KEEP_WIDTH-1:0] s_keep_i,
   input  logic                  s_last_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic                  perm_start_o,
   input  logic                  perm_done_i,
   input  logic [1599:0]         perm_state_i,
   output logic [1599:0]         state_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABSORB,
      S_PERM,
      S_CARRY,
      S_PAD,
      S_DONE
   } fsm_t;

   fsm_t              fsm;
   logic [1599:0]     state;
   logic [7:0]        pos;
   logic [7:0]        rb;
   logic [7:0]        dsbyte;
   logic [DWIDTH-1:0] carry_data;
   logic [7:0]        carry_cnt;
   logic              carry_pend;
   logic              last_pend;
   logic              final_pend;

   logic [7:0]        n;
   logic [7:0]        space;
   logic [8:0]        pos_sum;
   logic [DWIDTH-1:0] data_masked;
   logic [DWIDTH-1:0] carry_next;
   logic [1599:0]     rate_mask;
   logic [1599:0]     absorb_vec;
   logic [1599:0]     carry_vec;
   logic [1599:0]     pad_vec;

   // Beat alignment: the low n bytes are shifted up to pos and clipped at the
   // block boundary; whatever falls past the boundary becomes the carry.
   always_comb begin
      n = '0;
      for (int i = 0; i < KEEP_WIDTH; i++)
         n = n + {7'd0, s_keep_i[i]};
      data_masked = '0;
      for (int i = 0; i < KEEP_WIDTH; i++)
         if (i < int'(n))
            data_masked[8*i +: 8] = s_data_i[8*i +: 8];
      rate_mask = '0;
      for (int b = 0; b < MAX_RATE/8; b++)
         if (b < int'(rb))
            rate_mask[8*b +: 8] = 8'hFF;
      absorb_vec = ({{(1600-DWIDTH){1'b0}}, data_masked} << {pos, 3'b000}) & rate_mask;
      space      = rb - pos;
      carry_next = data_masked >> {space, 3'b000};
      pos_sum    = {1'b0, pos} + {1'b0, n};
      carry_vec  = {{(1600-DWIDTH){1'b0}}, carry_data};
      pad_vec    = ({1592'd0, dsbyte} << {pos, 3'b000})
                 ^ ({1592'd0, 8'h80} << {(rb - 8'd1), 3'b000});
   end

   assign state_o = state;

   // Control FSM; handshake outputs are registered alongside each transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm          <= S_IDLE;
         state        <= '0;
         pos          <= '0;
         rb           <= '0;
         dsbyte       <= '0;
         carry_data   <= '0;
         carry_cnt    <= '0;
         carry_pend   <= 1'b0;
         last_pend    <= 1'b0;
         final_pend   <= 1'b0;
         s_ready_o    <= 1'b0;
         perm_start_o <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         perm_start_o <= 1'b0;
         done_o       <= 1'b0;
         case (fsm)
            S_IDLE: begin
               if (start_i) begin
                  rb        <= 8'(rate_i >> 3);
                  dsbyte    <= dsbyte_i;
                  state     <= '0;
                  pos       <= '0;
                  fsm       <= S_ABSORB;
                  s_ready_o <= 1'b1;
                  busy_o    <= 1'b1;
               end
            end
            S_ABSORB: begin
               if (s_valid_i) begin
                  state <= state ^ absorb_vec;
                  if (pos_sum < {1'b0, rb}) begin
                     pos <= pos_sum[7:0];
                     if (s_last_i) begin
                        fsm       <= S_PAD;
                        s_ready_o <= 1'b0;
                     end
                  end else begin
                     pos          <= '0;
                     last_pend    <= s_last_i;
                     fsm          <= S_PERM;
                     s_ready_o    <= 1'b0;
                     perm_start_o <= 1'b1;
                     if (pos_sum > {1'b0, rb}) begin
                        carry_data <= carry_next;
                        carry_cnt  <= 8'(pos_sum - {1'b0, rb});
                        carry_pend <= 1'b1;
                     end
                  end
               end
            end
            S_PERM: begin
               if (perm_done_i) begin
                  state <= perm_state_i;
                  if (final_pend) begin
                     fsm    <= S_DONE;
                     done_o <= 1'b1;
                  end else if (carry_pend) begin
                     fsm <= S_CARRY;
                  end else if (last_pend) begin
                     fsm <= S_PAD;
                  end else begin
                     fsm       <= S_ABSORB;
                     s_ready_o <= 1'b1;
                  end
               end
            end
            S_CARRY: begin
               state      <= state ^ carry_vec;
               pos        <= carry_cnt;
               carry_pend <= 1'b0;
               if (last_pend) begin
                  fsm <= S_PAD;
               end else begin
                  fsm       <= S_ABSORB;
                  s_ready_o <= 1'b1;
               end
            end
            S_PAD: begin
               state        <= state ^ pad_vec;
               final_pend   <= 1'b1;
               last_pend    <= 1'b0;
               fsm          <= S_PERM;
               perm_start_o <= 1'b1;
            end
            S_DONE: begin
               carry_pend <= 1'b0;
               last_pend  <= 1'b0;
               final_pend <= 1'b0;
               fsm        <= S_IDLE;
               busy_o     <= 1'b0;
            end
            default: begin
               fsm       <= S_IDLE;
               s_ready_o <= 1'b0;
               busy_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule
